fifo_sync_param: RTL and testbench

- Single-clock, parametrised synchronous FIFO.
- Successor to the two-clock FIFO: one clock domain, configurable width and depth, programmable almost-full/almost-empty thresholds, a fill-level output, overflow/underflow error pulses, and an optional first-word-fall-through (FWFT) read mode.
- Used as the general buffering element between same-clock producer/consumer stages.

---
 rtl/fifo_sync_param.sv | 134 +++++++++++++
 tb/tb_fifo_sync_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised synchronous FIFO.
//
// Purpose: general buffering element between same-clock producer/consumer stages.
// Offers programmable almost-full/almost-empty thresholds, a fill-level output,
// overflow/underflow error pulses and an optional first-word-fall-through read mode.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   w_en, wdata  write request and data
//   r_en         read request (pop); in FWFT mode an acknowledge of the shown word
//   rdata        read data (registered in standard mode, mem[rd_ptr] in FWFT mode)
//   w_full       count == MEMORY_DEPTH
//   r_empty      count == 0
//   almost_full  count >= ALMOST_FULL_TH
//   almost_empty count <= ALMOST_EMPTY_TH
//   count        current number of stored entries
//   overflow     one-cycle pulse after a rejected write
//   underflow    one-cycle pulse after a rejected read
module fifo_sync_param #(
  parameter int unsigned MEMORY_WIDTH    = 8,
  parameter int unsigned MEMORY_DEPTH    = 16,
  parameter int unsigned ADDRESS_SIZE    = 4,
  parameter int unsigned ALMOST_FULL_TH  = 12,
  parameter int unsigned ALMOST_EMPTY_TH = 4,
  parameter bit          FWFT            = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [MEMORY_WIDTH-1:0] wdata,
  input  logic                    r_en,
  output logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    w_full,
  output logic                    r_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  typedef logic [ADDRESS_SIZE:0]   cnt_t;
  typedef logic [ADDRESS_SIZE-1:0] ptr_t;

  localparam cnt_t DepthCnt = cnt_t'(MEMORY_DEPTH);
  localparam cnt_t AfTh     = cnt_t'(ALMOST_FULL_TH);
  localparam cnt_t AeTh     = cnt_t'(ALMOST_EMPTY_TH);

  logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];

  ptr_t wr_ptr_q, rd_ptr_q;
  cnt_t count_q, count_d;
  logic w_full_q, w_full_d;
  logic r_empty_q, r_empty_d;
  logic almost_full_q, almost_full_d;
  logic almost_empty_q, almost_empty_d;
  logic overflow_q, underflow_q;
  logic wr_accept, rd_accept;

  // A write to a full FIFO is still accepted when a read frees a slot on the same edge.
  always_comb begin
    rd_accept = r_en & ~r_empty_q;
    wr_accept = w_en & (~w_full_q | rd_accept);
  end

  always_comb begin
    count_d = count_q;
    if (wr_accept && !rd_accept) begin
      count_d = count_q + cnt_t'(1);
    end else if (!wr_accept && rd_accept) begin
      count_d = count_q - cnt_t'(1);
    end
    // Flags are registered from the next count so they always agree with count.
    w_full_d       = (count_d == DepthCnt);
    r_empty_d      = (count_d == '0);
    almost_full_d  = (count_d >= AfTh);
    almost_empty_d = (count_d <= AeTh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      w_full_q       <= 1'b0;
      r_empty_q      <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (rd_accept) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      count_q        <= count_d;
      w_full_q       <= w_full_d;
      r_empty_q      <= r_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= w_en & ~wr_accept;
      underflow_q    <= r_en & r_empty_q;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= wdata;
  end

  if (FWFT) begin : gen_fwft
    // Head word shown combinationally; zero while empty keeps reset value clean.
    assign rdata = r_empty_q ? '0 : mem[rd_ptr_q];
  end else begin : gen_std
    logic [MEMORY_WIDTH-1:0] rdata_q;
    // At full with a simultaneous write, wr_ptr == rd_ptr: the old word is read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (rd_accept) begin
        rdata_q <= mem[rd_ptr_q];
      end
    end
    assign rdata = rdata_q;
  end

  assign count        = count_q;
  assign w_full       = w_full_q;
  assign r_empty      = r_empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a standard-mode and an FWFT instance share the same
// stimulus; a queue-based reference model predicts every output of both.
module tb_fifo_sync_param;

  localparam int W = 8;
  localparam int D = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic w_en = 1'b0;
  logic r_en = 1'b0;
  logic [W-1:0] wdata = '0;

  logic [W-1:0] rdata0, rdata1;
  logic full0, empty0, af0, ae0, ovf0, unf0;
  logic full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] count0, count1;

  fifo_sync_param #(.FWFT(1'b0)) dut_std (
    .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en), .rdata(rdata0),
    .w_full(full0), .r_empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_param #(.FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en), .rdata(rdata1),
    .w_full(full1), .r_empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model
  logic [W-1:0] q[$];
  logic [W-1:0] exp_std;
  logic exp_ovf, exp_unf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_std = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic model_edge();
    bit rd_ok, wr_ok;
    rd_ok = r_en && (q.size() > 0);
    wr_ok = w_en && ((q.size() < D) || rd_ok);
    exp_ovf = w_en && !wr_ok;
    exp_unf = r_en && !rd_ok;
    if (rd_ok) exp_std = q.pop_front();
    if (wr_ok) q.push_back(wdata);
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count", 32'(count0), 32'(n));
    chk("w_full", 32'(full0), 32'(n == D));
    chk("r_empty", 32'(empty0), 32'(n == 0));
    chk("almost_full", 32'(af0), 32'(n >= AF));
    chk("almost_empty", 32'(ae0), 32'(n <= AE));
    chk("overflow", 32'(ovf0), 32'(exp_ovf));
    chk("underflow", 32'(unf0), 32'(exp_unf));
    chk("rdata_std", 32'(rdata0), 32'(exp_std));
    chk("fwft_count", 32'(count1), 32'(n));
    chk("fwft_empty", 32'(empty1), 32'(n == 0));
    chk("fwft_flags", 32'({full1, af1, ae1, ovf1, unf1}),
        32'({n == D, n >= AF, n <= AE, exp_ovf, exp_unf}));
    if (n > 0) chk("rdata_fwft", 32'(rdata1), 32'(q[0]));
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r);
    w_en = w;
    wdata = d;
    r_en = r;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Reset asserted away from a clock edge; outputs must clear without an edge.
  task automatic async_reset();
    w_en = 1'b0;
    r_en = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_ae", 32'(ae0), 32'd1);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_af", 32'(af0), 32'd0);
    chk("rst_rdata", 32'(rdata0), 32'd0);
    chk("rst_ovf_unf", 32'({ovf0, unf0}), 32'd0);
    chk("rst_fwft_count", 32'(count1), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model();
  endtask

  typedef struct {
    logic w, r;
    logic [W-1:0] d;
    int cnt;
    logic full, empty, af, ae, ovf, unf;
    logic [W-1:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [W-1:0] d, logic r, int cnt, logic ovf,
                              logic unf, logic [W-1:0] rd);
    vec_t v;
    v.w = w; v.d = d; v.r = r; v.cnt = cnt;
    v.full = (cnt == D); v.empty = (cnt == 0);
    v.af = (cnt >= AF); v.ae = (cnt <= AE);
    v.ovf = ovf; v.unf = unf; v.rd = rd;
    return v;
  endfunction

  initial begin
    // Fill 1..16, overflow with 17, drain 16, then one underflowing read.
    for (int i = 0; i < D; i++) vecs.push_back(mk(1'b1, W'(i + 1), 1'b0, i + 1, 1'b0, 1'b0, '0));
    vecs.push_back(mk(1'b1, 8'd17, 1'b0, D, 1'b1, 1'b0, '0));
    for (int i = 0; i < D; i++) vecs.push_back(mk(1'b0, '0, 1'b1, D - 1 - i, 1'b0, 1'b0, W'(i + 1)));
    vecs.push_back(mk(1'b0, '0, 1'b1, 0, 1'b0, 1'b1, 8'd16));

    model_reset();
    @(negedge clk);
    async_reset();

    foreach (vecs[k]) begin
      cycle(vecs[k].w, vecs[k].d, vecs[k].r);
      chk($sformatf("vec%0d_count", k), 32'(count0), 32'(vecs[k].cnt));
      chk($sformatf("vec%0d_flags", k), 32'({full0, empty0, af0, ae0, ovf0, unf0}),
          32'({vecs[k].full, vecs[k].empty, vecs[k].af, vecs[k].ae, vecs[k].ovf, vecs[k].unf}));
      chk($sformatf("vec%0d_rdata", k), 32'(rdata0), 32'(vecs[k].rd));
    end

    // Simultaneous read/write at full: 0xAA must come out last.
    for (int i = 0; i < D; i++) cycle(1'b1, W'(i + 32), 1'b0);
    cycle(1'b1, 8'hAA, 1'b1);
    chk("full_rw_count", 32'(count0), 32'(D));
    chk("full_rw_full", 32'(full0), 32'd1);
    chk("full_rw_rdata", 32'(rdata0), 32'd32);
    for (int i = 0; i < D; i++) cycle(1'b0, '0, 1'b1);
    chk("full_rw_last", 32'(rdata0), 32'hAA);
    chk("full_rw_empty", 32'(empty0), 32'd1);

    // Simultaneous read/write at empty: write wins, read underflows.
    cycle(1'b1, 8'h5, 1'b1);
    chk("empty_rw_unf", 32'(unf0), 32'd1);
    chk("empty_rw_count", 32'(count0), 32'd1);
    chk("fwft_fall_through", 32'(rdata1), 32'h5);
    chk("fwft_not_empty", 32'(empty1), 32'd0);
    cycle(1'b1, 8'h6, 1'b0);
    chk("unf_one_cycle", 32'(unf0), 32'd0);
    cycle(1'b0, '0, 1'b1);
    chk("fwft_next_word", 32'(rdata1), 32'h6);
    chk("std_pop_word", 32'(rdata0), 32'h5);
    cycle(1'b0, '0, 1'b1);

    // Wrap-around: 10 in / 10 out, three times.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, W'(rep * 10 + i + 100), 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
    end

    // Reset mid-traffic with 7 entries stored.
    for (int i = 0; i < 7; i++) cycle(1'b1, W'(i + 60), 1'b0);
    @(negedge clk);
    async_reset();
    cycle(1'b1, 8'h3, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("post_reset_rdata", 32'(rdata0), 32'h3);

    // Random traffic with phases biased toward filling and draining.
    for (int ph = 0; ph < 12; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 55;
      rp = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 55;
      for (int i = 0; i < 150; i++) begin
        cycle(($urandom_range(99) < wp), W'($urandom), ($urandom_range(99) < rp));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
